// File: rtl/riscv_dmem_ctrl_pkg.sv
// Shared definitions for the RV32I data-memory controller.
// - byte_sel encodings, which match the control decoder's outputs
// - FSM state codes
// - store-data lane replication helper
package riscv_dmem_ctrl_pkg;

  localparam logic [3:0] MEM_SEL_BYTE = 4'b0001;
  localparam logic [3:0] MEM_SEL_HALF = 4'b0011;
  localparam logic [3:0] MEM_SEL_WORD = 4'b1111;

  typedef enum logic [1:0] {
    DMEM_ST_IDLE   = 2'd0,
    DMEM_ST_ACCESS = 2'd1,
    DMEM_ST_RESP   = 2'd2
  } dmem_state_e;

  // Store data arrives right-justified. Replicating it across the word
  // places a copy in every lane the byte enables might select.
  function automatic logic [31:0] lane_wdata(input logic [3:0]  sel,
                                             input logic [31:0] wdata);
    logic [31:0] r;
    case (sel)
      MEM_SEL_BYTE: r = {4{wdata[7:0]}};
      MEM_SEL_HALF: r = {2{wdata[15:0]}};
      default:      r = wdata;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/riscv_dmem_sram.sv
// DEPTH x 32 synchronous single-port data RAM.
// Has per-byte write enables and a registered read port.
// Contents are not reset.
// Ports:
//   clk    - clock
//   addr   - word index
//   we     - byte write enables (bit b writes wdata[8b+7:8b])
//   wdata  - write data
//   re     - read enable; rdata updates on the next edge
//   rdata  - registered read data, held while re is low
module riscv_dmem_sram #(
  parameter int DEPTH = 1024,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic [AW-1:0] addr,
  input  logic [3:0]    we,
  input  logic [31:0]   wdata,
  input  logic          re,
  output logic [31:0]   rdata
);

  logic [31:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    for (int b = 0; b < 4; b++) begin
      if (we[b]) mem[addr][8*b +: 8] <= wdata[8*b +: 8];
    end
    if (re) rdata <= mem[addr];
  end

endmodule

// File: rtl/riscv_dmem_ctrl.sv
// Data-memory responder for the RV32I core.
// Takes one load/store request per transaction and aligns it into byte
// lanes of a word-wide synchronous RAM. Returns sign- or zero-extended load
// data, or a store acknowledge. Misaligned, illegal-size and out-of-range
// accesses complete the handshake with err=1 and do not touch the RAM.
//
// Ports:
//   i_clk, i_rstn                 - clock, async active-low reset
//   i_req_valid / o_req_ready     - request handshake
//   i_req_addr                    - byte address
//   i_req_wr_en                   - 1 store, 0 load
//   i_req_byte_sel                - byte/half/word encoding
//   i_req_unsigned                - zero-extend loads
//   i_req_wdata                   - right-justified store data
//   o_rsp_valid / i_rsp_ready     - response handshake
//   o_rsp_rdata                   - extended load data (0 for stores/errors)
//   o_rsp_err                     - access error
//
// state  | meaning
// IDLE   | ready for a request; latches it and its error flag on valid
// ACCESS | RAM write, or RAM read issue (skipped on error)
// RESP   | first cycle captures the response; then held until i_rsp_ready
module riscv_dmem_ctrl
  import riscv_dmem_ctrl_pkg::*;
#(
  parameter int          DEPTH     = 1024,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic        i_clk,
  input  logic        i_rstn,
  input  logic        i_req_valid,
  output logic        o_req_ready,
  input  logic [31:0] i_req_addr,
  input  logic        i_req_wr_en,
  input  logic [3:0]  i_req_byte_sel,
  input  logic        i_req_unsigned,
  input  logic [31:0] i_req_wdata,
  output logic        o_rsp_valid,
  input  logic        i_rsp_ready,
  output logic [31:0] o_rsp_rdata,
  output logic        o_rsp_err
);

  localparam int AW = $clog2(DEPTH);

  dmem_state_e state_q, state_d;

  logic [AW-1:0] idx_q;
  logic [1:0]    lane_q;
  logic          wr_q;
  logic [3:0]    sel_q;
  logic          uns_q;
  logic [31:0]   wdata_q;
  logic          err_q;

  logic          rsp_valid_q;
  logic [31:0]   rsp_rdata_q;
  logic          rsp_err_q;

  // A 33-bit subtraction exposes the borrow, which means addr < BASE_ADDR.
  logic          below_base;
  logic [29:0]   word_off;
  logic          sel_legal;
  logic          req_err;

  assign {below_base, word_off} =
    31'(({1'b0, i_req_addr} - {1'b0, BASE_ADDR}) >> 2);

  assign sel_legal = (i_req_byte_sel == MEM_SEL_BYTE) ||
                     (i_req_byte_sel == MEM_SEL_HALF) ||
                     (i_req_byte_sel == MEM_SEL_WORD);

  assign req_err = !sel_legal
                || ((i_req_byte_sel == MEM_SEL_HALF) && i_req_addr[0])
                || ((i_req_byte_sel == MEM_SEL_WORD) && (i_req_addr[1:0] != 2'b00))
                || below_base
                || ({2'b00, word_off} >= 32'(DEPTH));

  logic [3:0]  ram_we;
  logic        ram_re;
  logic [31:0] ram_rdata;

  assign ram_we = (state_q == DMEM_ST_ACCESS && !err_q && wr_q)
                  ? 4'(sel_q << lane_q) : 4'b0000;
  assign ram_re = (state_q == DMEM_ST_ACCESS) && !err_q && !wr_q;

  riscv_dmem_sram #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_sram (
    .clk   (i_clk),
    .addr  (idx_q),
    .we    (ram_we),
    .wdata (lane_wdata(sel_q, wdata_q)),
    .re    (ram_re),
    .rdata (ram_rdata)
  );

  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_data;

  always_comb begin
    ld_byte = ram_rdata[8*lane_q +: 8];
    ld_half = lane_q[1] ? ram_rdata[31:16] : ram_rdata[15:0];
    ld_data = 32'h0;
    case (sel_q)
      MEM_SEL_BYTE: ld_data = uns_q ? {24'h0, ld_byte} : {{24{ld_byte[7]}}, ld_byte};
      MEM_SEL_HALF: ld_data = uns_q ? {16'h0, ld_half} : {{16{ld_half[15]}}, ld_half};
      MEM_SEL_WORD: ld_data = ram_rdata;
      default:      ld_data = 32'h0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      DMEM_ST_IDLE:   if (i_req_valid) state_d = DMEM_ST_ACCESS;
      DMEM_ST_ACCESS: state_d = DMEM_ST_RESP;
      DMEM_ST_RESP:   if (rsp_valid_q && i_rsp_ready) state_d = DMEM_ST_IDLE;
      default:        state_d = DMEM_ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) state_q <= DMEM_ST_IDLE;
    else         state_q <= state_d;
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      idx_q   <= '0;
      lane_q  <= 2'b00;
      wr_q    <= 1'b0;
      sel_q   <= 4'h0;
      uns_q   <= 1'b0;
      wdata_q <= 32'h0;
      err_q   <= 1'b0;
    end else if (state_q == DMEM_ST_IDLE && i_req_valid) begin
      idx_q   <= word_off[AW-1:0];
      lane_q  <= i_req_addr[1:0];
      wr_q    <= i_req_wr_en;
      sel_q   <= i_req_byte_sel;
      uns_q   <= i_req_unsigned;
      wdata_q <= i_req_wdata;
      err_q   <= req_err;
    end
  end

  // RAM read data lands at the end of ACCESS. The first RESP cycle
  // registers the extended value, so outputs stay stable for any stall.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= 32'h0;
      rsp_err_q   <= 1'b0;
    end else if (state_q == DMEM_ST_RESP && !rsp_valid_q) begin
      rsp_valid_q <= 1'b1;
      rsp_rdata_q <= (err_q || wr_q) ? 32'h0 : ld_data;
      rsp_err_q   <= err_q;
    end else if (rsp_valid_q && i_rsp_ready) begin
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= 32'h0;
      rsp_err_q   <= 1'b0;
    end
  end

  assign o_req_ready = (state_q == DMEM_ST_IDLE);
  assign o_rsp_valid = rsp_valid_q;
  assign o_rsp_rdata = rsp_rdata_q;
  assign o_rsp_err   = rsp_err_q;

endmodule
